// File: rtl/shared_timer_arbiter.sv
// Round-robin arbiter sharing one up-counter among NUM_REQ go/done clients.
// Optional: SHARED_TIMER_ARB_ABORT_EN lets the owner abort its run by dropping req.
//
// state  | meaning
// S_IDLE | no owner; arbitrate pending requests from rr_ptr
// S_RUN  | counter owned by r_owner; done fires when count reaches term
module shared_timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [IDX_W-1:0]         owner,
    output logic                     busy,
    output logic [CNT_W-1:0]         cnt_val,
    output logic [NUM_REQ-1:0]       done
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_term;
    logic [IDX_W-1:0]   r_rr_ptr;

    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W-1:0]   w_term_nxt;
    logic [IDX_W-1:0]   w_rr_ptr_nxt;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic               w_hit;
    logic               w_abort;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && req[IDX_W'(idx)]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(idx);
            end
        end
    end

    assign w_hit = (r_state == S_RUN) && (r_count == r_term);

`ifdef SHARED_TIMER_ARB_ABORT_EN
    // Completion wins over a same-cycle abort.
    assign w_abort = (r_state == S_RUN) && !req[r_owner] && !w_hit;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_owner_nxt  = r_owner;
        w_count_nxt  = r_count;
        w_term_nxt   = r_term;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt   = '0;
                w_count_nxt = '0;
                if (w_found) begin
                    w_state_nxt = S_RUN;
                    w_gnt_nxt   = NUM_REQ'(1) << w_win;
                    w_owner_nxt = w_win;
                    w_term_nxt  = len[int'(w_win)*CNT_W +: CNT_W];
                    if (w_win == IDX_W'(NUM_REQ - 1))
                        w_rr_ptr_nxt = '0;
                    else
                        w_rr_ptr_nxt = w_win + 1'b1;
                end
            end
            S_RUN: begin
                if (w_hit || w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_count  <= '0;
            r_term   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_count  <= w_count_nxt;
            r_term   <= w_term_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        done = '0;
        if (w_hit) done[r_owner] = 1'b1;
    end

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = (r_state == S_RUN);
    assign cnt_val = r_count;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Bench for shared_timer_arbiter: directed scenarios plus random traffic, checked
// against a remaining-cycles model of the arbitration rules.
module tb_shared_timer_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req   = '0;
    logic [N*W-1:0] len  = '0;
    logic [N-1:0]  gnt;
    logic [1:0]    owner;
    logic          busy;
    logic [W-1:0]  cnt_val;
    logic [N-1:0]  done;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: who holds the timer, how many RUN cycles remain, the run length.
    int m_active, m_who, m_left, m_total, m_ptr, m_last;

    shared_timer_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .cnt_val (cnt_val),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 0; m_who = 0; m_left = 0; m_total = 0; m_ptr = 0; m_last = 0;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++)
            if (r[(start + i) % N]) return (start + i) % N;
        return -1;
    endfunction

    task automatic model_edge();
        int k;
        if (!rst_n) begin
            model_reset();
        end else if (!m_active) begin
            k = pick(req, m_ptr);
            if (k >= 0) begin
                m_active = 1;
                m_who    = k;
                m_last   = k;
                m_total  = int'(len[k*W +: W]) + 1;
                m_left   = m_total;
                m_ptr    = (k + 1) % N;
            end
        end else if (m_left == 1) begin
            m_active = 0;
        end else begin
`ifdef SHARED_TIMER_ARB_ABORT_EN
            if (!req[m_who]) m_active = 0;
            else m_left = m_left - 1;
`else
            m_left = m_left - 1;
`endif
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_gnt, e_done;
        logic [1:0]   e_owner;
        logic         e_busy;
        logic [W-1:0] e_cnt;
        e_gnt = '0; e_done = '0; e_cnt = '0;
        e_busy  = (m_active != 0);
        e_owner = 2'(m_last);
        if (m_active) begin
            e_gnt[m_who] = 1'b1;
            e_cnt = W'(m_total - m_left);
            if (m_left == 1) e_done[m_who] = 1'b1;
        end
        n_vec++;
        assert (gnt === e_gnt) else begin
            n_fail++; $error("FAIL gnt: observed %b expected %b", gnt, e_gnt);
        end
        n_vec++;
        assert (owner === e_owner) else begin
            n_fail++; $error("FAIL owner: observed %0d expected %0d", owner, e_owner);
        end
        n_vec++;
        assert (busy === e_busy) else begin
            n_fail++; $error("FAIL busy: observed %b expected %b", busy, e_busy);
        end
        n_vec++;
        assert (cnt_val === e_cnt) else begin
            n_fail++; $error("FAIL cnt_val: observed %0d expected %0d", cnt_val, e_cnt);
        end
        n_vec++;
        assert (done === e_done) else begin
            n_fail++; $error("FAIL done: observed %b expected %b", done, e_done);
        end
    endtask

    task automatic step(input logic rs, input logic [N-1:0] rq, input logic [N*W-1:0] ln);
        @(negedge clk);
        rst_n = rs;
        req   = rq;
        len   = ln;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
    endtask

    task automatic steps(input int n, input logic [N-1:0] rq, input logic [N*W-1:0] ln);
        for (int i = 0; i < n; i++) step(1'b1, rq, ln);
    endtask

    initial begin
        logic [N-1:0]   r_rq;
        logic [N*W-1:0] r_ln;
        model_reset();

        // Reset held with all requests high, then release.
        step(1'b0, 4'hF, 16'hFFFF);
        step(1'b0, 4'hF, 16'hFFFF);
        step(1'b1, 4'h0, 16'h0000);

        // Async reset mid-run at count 2.
        step(1'b1, 4'b0001, 16'h0005);
        steps(2, 4'b0001, 16'h0005);
        @(negedge clk);
        #1;
        check_outputs();
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        assert (gnt === 4'b0000) else begin
            n_fail++; $error("FAIL async_gnt: observed %b expected 0000", gnt);
        end
        n_vec++;
        assert (busy === 1'b0) else begin
            n_fail++; $error("FAIL async_busy: observed %b expected 0", busy);
        end
        n_vec++;
        assert (cnt_val === 4'd0) else begin
            n_fail++; $error("FAIL async_cnt: observed %0d expected 0", cnt_val);
        end
        n_vec++;
        assert (done === 4'b0000) else begin
            n_fail++; $error("FAIL async_done: observed %b expected 0000", done);
        end
        model_reset();
        @(posedge clk);
        model_edge();
        steps(3, 4'b0011, 16'h0000);
        steps(4, 4'b0000, 16'h0000);

        // Single request, len0 = 3.
        steps(5, 4'b0001, 16'h0003);
        steps(3, 4'b0000, 16'h0003);

        // Round robin, all len = 1.
        steps(18, 4'hF, 16'h1111);
        steps(3, 4'h0, 16'h1111);

        // len2 = 0, then len2 = F with a mid-run len change.
        steps(2, 4'b0100, 16'h0000);
        steps(2, 4'b0000, 16'h0000);
        steps(9, 4'b0100, 16'h0F00);
        steps(9, 4'b0100, 16'h0300);
        steps(3, 4'b0000, 16'h0300);

        // Fairness: req0 held, req3 raised during requester 0's run.
        steps(2, 4'b0001, 16'h0003);
        steps(10, 4'b1001, 16'h0003);
        steps(4, 4'b0000, 16'h0003);

        // Owner drops req mid-run.
        steps(6, 4'b0010, 16'h0070);
        steps(10, 4'b0000, 16'h0070);

        // Random traffic.
        r_rq = '0;
        r_ln = '0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) r_rq = N'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) r_ln = (N*W)'($urandom);
            step(1'b1, r_rq, r_ln);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
